i2c_slave_regfile: RTL and testbench

//  Synthesizable I2C slave holding a NUM_REGS x 8 register file. Follows the

---
 rtl/i2c_slave_regfile_if.sv | 25 ++
 rtl/i2c_slave_regfile.sv | 257 +++++++++++++++++++++++++
 tb/tb_i2c_slave_regfile.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/i2c_slave_regfile_if.sv
// I2C slave register-file bus bundle: pin-level I2C signals plus the
// host-side register read port and write-notify port.
interface i2c_slave_regfile_if #(
  parameter int PTR_W = 4
);
  logic             i_scl;
  logic             i_sda;
  logic             o_sda_oe;
  logic [PTR_W-1:0] i_rd_addr;
  logic [7:0]       o_rd_data;
  logic             o_wr_valid;
  logic [PTR_W-1:0] o_wr_addr;
  logic [7:0]       o_wr_data;
  logic             o_busy;

  modport slave (
    input  i_scl, i_sda, i_rd_addr,
    output o_sda_oe, o_rd_data, o_wr_valid, o_wr_addr, o_wr_data, o_busy
  );

  modport master (
    output i_scl, i_sda, i_rd_addr,
    input  o_sda_oe, o_rd_data, o_wr_valid, o_wr_addr, o_wr_data, o_busy
  );
endinterface

// File: rtl/i2c_slave_regfile.sv
// I2C slave with a NUM_REGS x 8 register file. Frame: device address,
// register pointer, then data bytes (write) or a repeated START and
// data reads. Pointer auto-increments with wrap; SCL is never stretched.
module i2c_slave_regfile #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h50,
  parameter int         NUM_REGS    = 16,
  parameter logic [7:0] RESET_VALUE = 8'h00
) (
  input  logic               i_clk,
  input  logic               i_rst,
  i2c_slave_regfile_if.slave bus
);
  localparam int               PTR_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(NUM_REGS - 1);
  localparam logic [8:0]       NUM_REGS_9 = 9'(NUM_REGS);

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_DEV       = 4'd1,
    ST_DEV_ACK   = 4'd2,
    ST_REG       = 4'd3,
    ST_REG_ACK   = 4'd4,
    ST_WR        = 4'd5,
    ST_WR_ACK    = 4'd6,
    ST_RD        = 4'd7,
    ST_RD_ACK    = 4'd8,
    ST_WAIT_STOP = 4'd9
  } state_t;

  logic [1:0]       r_scl_sync;
  logic [1:0]       r_sda_sync;
  logic             r_scl_d;
  logic             r_sda_d;
  state_t           r_state;
  logic [2:0]       r_bit_cnt;
  logic [7:0]       r_shift;
  logic             r_rw;
  logic             r_ack_flag;
  logic [PTR_W-1:0] r_ptr;
  logic [7:0]       r_mem [NUM_REGS];
  logic             r_sda_oe;
  logic             r_wr_valid;
  logic [PTR_W-1:0] r_wr_addr;
  logic [7:0]       r_wr_data;
  logic             r_busy;

  logic             w_scl_s;
  logic             w_sda_s;
  logic             w_scl_rise;
  logic             w_scl_fall;
  logic             w_start;
  logic             w_stop;
  logic [7:0]       w_rx_byte;
  logic             w_rd_in_range;

  // Pointer increment with wrap at the last implemented register.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == LAST_PTR) begin
      ptr_inc = '0;
    end else begin
      ptr_inc = p + PTR_W'(1);
    end
  endfunction

  assign w_scl_s    = r_scl_sync[1];
  assign w_sda_s    = r_sda_sync[1];
  assign w_scl_rise = w_scl_s & ~r_scl_d;
  assign w_scl_fall = ~w_scl_s & r_scl_d;
  // SCL must be high on both samples so an SCL edge is never mistaken for START/STOP.
  assign w_start    = w_scl_s & r_scl_d & r_sda_d & ~w_sda_s;
  assign w_stop     = w_scl_s & r_scl_d & ~r_sda_d & w_sda_s;
  assign w_rx_byte  = {r_shift[6:0], w_sda_s};

  assign w_rd_in_range  = (32'(bus.i_rd_addr) < NUM_REGS);
  assign bus.o_rd_data  = w_rd_in_range ? r_mem[bus.i_rd_addr] : RESET_VALUE;
  assign bus.o_sda_oe   = r_sda_oe;
  assign bus.o_wr_valid = r_wr_valid;
  assign bus.o_wr_addr  = r_wr_addr;
  assign bus.o_wr_data  = r_wr_data;
  assign bus.o_busy     = r_busy;

  // Two-flop synchronizers for the asynchronous pins plus one history flop for edges.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_scl_sync <= 2'b11;
      r_sda_sync <= 2'b11;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[0], bus.i_scl};
      r_sda_sync <= {r_sda_sync[0], bus.i_sda};
      r_scl_d    <= r_scl_sync[1];
      r_sda_d    <= r_sda_sync[1];
    end
  end

  // Protocol FSM, register file and all registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_bit_cnt  <= 3'd0;
      r_shift    <= 8'h00;
      r_rw       <= 1'b0;
      r_ack_flag <= 1'b0;
      r_ptr      <= '0;
      r_sda_oe   <= 1'b0;
      r_wr_valid <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= 8'h00;
      r_busy     <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        r_mem[i] <= RESET_VALUE;
      end
    end else begin
      r_wr_valid <= 1'b0;
      if (w_stop) begin
        r_state  <= ST_IDLE;
        r_busy   <= 1'b0;
        r_sda_oe <= 1'b0;
      end else if (w_start) begin
        // Fresh or repeated START: pointer is deliberately kept.
        r_state    <= ST_DEV;
        r_bit_cnt  <= 3'd0;
        r_ack_flag <= 1'b0;
        r_busy     <= 1'b0;
        r_sda_oe   <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_sda_oe <= 1'b0;
          end
          ST_DEV: begin
            if (w_scl_rise) begin
              r_shift   <= w_rx_byte;
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) begin
                if (r_shift[6:0] == SLAVE_ADDR) begin
                  r_state    <= ST_DEV_ACK;
                  r_rw       <= w_sda_s;
                  r_busy     <= 1'b1;
                  r_ack_flag <= 1'b0;
                end else begin
                  r_state <= ST_WAIT_STOP;
                end
              end
            end
          end
          ST_DEV_ACK: begin
            // First fall starts the ACK; second fall ends the ACK clock.
            if (w_scl_fall) begin
              if (!r_ack_flag) begin
                r_sda_oe   <= 1'b1;
                r_ack_flag <= 1'b1;
              end else begin
                r_ack_flag <= 1'b0;
                r_bit_cnt  <= 3'd0;
                if (r_rw) begin
                  r_state  <= ST_RD;
                  r_shift  <= r_mem[r_ptr];
                  r_sda_oe <= ~r_mem[r_ptr][7];
                end else begin
                  r_state  <= ST_REG;
                  r_sda_oe <= 1'b0;
                end
              end
            end
          end
          ST_REG: begin
            if (w_scl_rise) begin
              r_shift   <= w_rx_byte;
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) begin
                if ({1'b0, w_rx_byte} < NUM_REGS_9) begin
                  r_ptr      <= w_rx_byte[PTR_W-1:0];
                  r_state    <= ST_REG_ACK;
                  r_ack_flag <= 1'b0;
                end else begin
                  r_state <= ST_WAIT_STOP;
                  r_busy  <= 1'b0;
                end
              end
            end
          end
          ST_REG_ACK, ST_WR_ACK: begin
            if (w_scl_fall) begin
              if (!r_ack_flag) begin
                r_sda_oe   <= 1'b1;
                r_ack_flag <= 1'b1;
              end else begin
                r_ack_flag <= 1'b0;
                r_bit_cnt  <= 3'd0;
                r_state    <= ST_WR;
                r_sda_oe   <= 1'b0;
              end
            end
          end
          ST_WR: begin
            if (w_scl_rise) begin
              r_shift   <= w_rx_byte;
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) begin
                r_mem[r_ptr] <= w_rx_byte;
                r_wr_valid   <= 1'b1;
                r_wr_addr    <= r_ptr;
                r_wr_data    <= w_rx_byte;
                r_ptr        <= ptr_inc(r_ptr);
                r_state      <= ST_WR_ACK;
                r_ack_flag   <= 1'b0;
              end
            end
          end
          ST_RD: begin
            // Each fall advances to the next bit; the fall after bit 0 releases SDA.
            if (w_scl_fall) begin
              if (r_bit_cnt == 3'd7) begin
                r_sda_oe   <= 1'b0;
                r_state    <= ST_RD_ACK;
                r_ack_flag <= 1'b0;
              end else begin
                r_shift   <= {r_shift[6:0], 1'b0};
                r_sda_oe  <= ~r_shift[6];
                r_bit_cnt <= r_bit_cnt + 3'd1;
              end
            end
          end
          ST_RD_ACK: begin
            if (w_scl_rise) begin
              r_ptr <= ptr_inc(r_ptr);
              if (w_sda_s) begin
                r_state <= ST_WAIT_STOP;
                r_busy  <= 1'b0;
              end else begin
                r_ack_flag <= 1'b1;
              end
            end else if (w_scl_fall && r_ack_flag) begin
              r_ack_flag <= 1'b0;
              r_bit_cnt  <= 3'd0;
              r_state    <= ST_RD;
              r_shift    <= r_mem[r_ptr];
              r_sda_oe   <= ~r_mem[r_ptr][7];
            end else begin
              r_sda_oe <= 1'b0;
            end
          end
          ST_WAIT_STOP: begin
            r_sda_oe <= 1'b0;
          end
          default: begin
            r_state  <= ST_IDLE;
            r_sda_oe <= 1'b0;
            r_busy   <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Directed bench for i2c_slave_regfile: bit-banged I2C master with an
// open-drain SDA model and a write-notify logger.
module tb_i2c_slave_regfile;
  localparam int Q = 50;  // quarter SCL period, 5 clk

  logic clk = 1'b0;
  logic rst;
  logic m_scl;
  logic m_sda;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   wv_cnt   = 0;
  logic [3:0] wv_addr [16];
  logic [7:0] wv_data [16];
  logic       ack;
  logic [7:0] rb;

  always #5 clk = ~clk;

  i2c_slave_regfile_if #(.PTR_W(4)) bus ();

  assign bus.i_scl = m_scl;
  assign bus.i_sda = m_sda & ~bus.o_sda_oe;

  i2c_slave_regfile #(
    .SLAVE_ADDR (7'h50),
    .NUM_REGS   (16),
    .RESET_VALUE(8'h00)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  // log every cycle wr_valid is high
  always @(posedge clk) begin
    if (bus.o_wr_valid === 1'b1) begin
      if (wv_cnt < 16) begin
        wv_addr[wv_cnt] <= bus.o_wr_addr;
        wv_data[wv_cnt] <= bus.o_wr_data;
      end
      wv_cnt <= wv_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic rd_check(input string tag, input logic [3:0] a, input logic [7:0] e);
    bus.i_rd_addr = a;
    #10;
    check(tag, 32'(bus.o_rd_data), 32'(e));
  endtask

  task automatic send_bit(input logic b);
    m_sda = b; #Q; m_scl = 1'b1; #(2*Q); m_scl = 1'b0; #Q;
  endtask

  task automatic recv_bit(output logic b);
    m_sda = 1'b1; #Q; m_scl = 1'b1; #Q; b = bus.i_sda; #Q; m_scl = 1'b0; #Q;
  endtask

  task automatic i2c_start;
    m_sda = 1'b1; #Q; m_scl = 1'b1; #Q; m_sda = 1'b0; #Q; m_scl = 1'b0; #Q;
  endtask

  task automatic i2c_stop;
    m_sda = 1'b0; #Q; m_scl = 1'b1; #Q; m_sda = 1'b1; #(2*Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic a);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    recv_bit(a);
  endtask

  task automatic recv_byte(output logic [7:0] b, input logic mack);
    logic bt;
    b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      recv_bit(bt);
      b = {b[6:0], bt};
    end
    send_bit(mack);
  endtask

  initial begin
    rst = 1'b1; m_scl = 1'b1; m_sda = 1'b1; bus.i_rd_addr = 4'd0;
    #30;
    rst = 1'b0;
    #10;
    check("rst_sda_oe", 32'(bus.o_sda_oe), 32'd0);
    check("rst_wr_valid", 32'(bus.o_wr_valid), 32'd0);
    check("rst_busy", 32'(bus.o_busy), 32'd0);
    rd_check("rst_reg0", 4'd0, 8'h00);
    rd_check("rst_regF", 4'd15, 8'h00);

    // 1: single write reg3 = A5
    i2c_start;
    send_byte(8'hA0, ack); check("t1_dev_ack", 32'(ack), 32'd0);
    check("t1_busy", 32'(bus.o_busy), 32'd1);
    send_byte(8'h03, ack); check("t1_reg_ack", 32'(ack), 32'd0);
    send_byte(8'hA5, ack); check("t1_data_ack", 32'(ack), 32'd0);
    i2c_stop;
    check("t1_wv_cnt", 32'(wv_cnt), 32'd1);
    check("t1_wv_addr", 32'(wv_addr[0]), 32'd3);
    check("t1_wv_data", 32'(wv_data[0]), 32'hA5);
    rd_check("t1_reg3", 4'd3, 8'hA5);
    check("t1_busy_end", 32'(bus.o_busy), 32'd0);

    // 2: burst from 0x0E with wrap
    i2c_start;
    send_byte(8'hA0, ack);
    send_byte(8'h0E, ack);
    send_byte(8'h11, ack); check("t2_ack1", 32'(ack), 32'd0);
    send_byte(8'h22, ack); check("t2_ack2", 32'(ack), 32'd0);
    send_byte(8'h33, ack); check("t2_ack3", 32'(ack), 32'd0);
    i2c_stop;
    check("t2_wv_cnt", 32'(wv_cnt), 32'd4);
    check("t2_wrap_addr", 32'(wv_addr[3]), 32'd0);
    check("t2_wrap_data", 32'(wv_data[3]), 32'h33);
    rd_check("t2_regE", 4'd14, 8'h11);
    rd_check("t2_regF", 4'd15, 8'h22);
    rd_check("t2_reg0", 4'd0, 8'h33);

    // 3: load reg5/6, then pointer write + repeated START + 2-byte read
    i2c_start;
    send_byte(8'hA0, ack);
    send_byte(8'h05, ack);
    send_byte(8'h3C, ack);
    send_byte(8'hC3, ack);
    i2c_stop;
    i2c_start;
    send_byte(8'hA0, ack);
    send_byte(8'h05, ack); check("t3_reg_ack", 32'(ack), 32'd0);
    i2c_start;
    send_byte(8'hA1, ack); check("t3_rdev_ack", 32'(ack), 32'd0);
    recv_byte(rb, 1'b0); check("t3_rd_reg5", 32'(rb), 32'h3C);
    check("t3_busy_mid", 32'(bus.o_busy), 32'd1);
    recv_byte(rb, 1'b1); check("t3_rd_reg6", 32'(rb), 32'hC3);
    i2c_stop;
    check("t3_busy_end", 32'(bus.o_busy), 32'd0);
    check("t3_wv_cnt", 32'(wv_cnt), 32'd6);

    // 4: wrong device address, then a good transfer
    i2c_start;
    send_byte(8'hA2, ack); check("t4_dev_nack", 32'(ack), 32'd1);
    check("t4_busy", 32'(bus.o_busy), 32'd0);
    send_byte(8'h77, ack); check("t4_data_nack", 32'(ack), 32'd1);
    i2c_stop;
    check("t4_wv_none", 32'(wv_cnt), 32'd6);
    i2c_start;
    send_byte(8'hA0, ack); check("t4_dev_ack", 32'(ack), 32'd0);
    send_byte(8'h07, ack);
    send_byte(8'h99, ack);
    i2c_stop;
    rd_check("t4_reg7", 4'd7, 8'h99);
    check("t4_wv_cnt", 32'(wv_cnt), 32'd7);

    // 5: out-of-range register pointer; pointer stays at 8
    i2c_start;
    send_byte(8'hA0, ack);
    send_byte(8'h20, ack); check("t5_reg_nack", 32'(ack), 32'd1);
    check("t5_busy", 32'(bus.o_busy), 32'd0);
    send_byte(8'h55, ack); check("t5_data_nack", 32'(ack), 32'd1);
    i2c_stop;
    check("t5_wv_none", 32'(wv_cnt), 32'd7);
    rd_check("t5_reg0", 4'd0, 8'h33);
    i2c_start;
    send_byte(8'hA1, ack);
    recv_byte(rb, 1'b1); check("t5_rd_ptr8", 32'(rb), 32'h00);
    i2c_stop;

    // 6: reset while slave drives a 0 bit of reg0 (0x33)
    i2c_start;
    send_byte(8'hA0, ack);
    send_byte(8'h00, ack);
    i2c_start;
    send_byte(8'hA1, ack);
    check("t6_driving", 32'(bus.o_sda_oe), 32'd1);
    rst = 1'b1;
    #10;
    check("t6_rst_release", 32'(bus.o_sda_oe), 32'd0);
    rst = 1'b0;
    check("t6_busy", 32'(bus.o_busy), 32'd0);
    rd_check("t6_reg0", 4'd0, 8'h00);
    rd_check("t6_regE", 4'd14, 8'h00);
    i2c_stop;
    i2c_start;
    send_byte(8'hA0, ack); check("t6_dev_ack", 32'(ack), 32'd0);
    send_byte(8'h02, ack);
    send_byte(8'h5A, ack); check("t6_data_ack", 32'(ack), 32'd0);
    i2c_stop;
    rd_check("t6_reg2", 4'd2, 8'h5A);
    check("t6_wv_cnt", 32'(wv_cnt), 32'd8);
    check("t6_wv_addr", 32'(wv_addr[7]), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
